// File: rtl/stump_control.sv
// Stump sequencing/decode controller: FETCH -> EXECUTE (-> MEMORY), condition codes, branch evaluation.
// Optional memory wait states are enabled by defining STUMP_CTRL_MEM_WAIT_EN.
module stump_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        state_fetch,
  output logic        state_execute,
  output logic        state_memory,
  output logic        ir_en,
  output logic        pc_inc,
  output logic        pc_wr,
  output logic        reg_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  alu_func,
  output logic        alu_c_in,
  output logic [3:0]  cc,
  output logic        branch_taken
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_MEMORY  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cc_q, cc_d;
  logic        done_s;
  logic [2:0]  opcode_s;
  logic        unused_s;

  // Odd condition codes are the complement of the even code below them.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic r;
    case (c[3:1])
      3'd0:    r = 1'b1;
      3'd1:    r = ~f[0] & ~f[2];
      3'd2:    r = ~f[0];
      3'd3:    r = ~f[2];
      3'd4:    r = ~f[1];
      3'd5:    r = ~f[3];
      3'd6:    r = (f[3] == f[1]);
      3'd7:    r = ~f[2] & (f[3] == f[1]);
      default: r = 1'b0;
    endcase
    return r ^ c[0];
  endfunction

`ifdef STUMP_CTRL_MEM_WAIT_EN
  assign done_s = mem_ready;
`else
  assign done_s = 1'b1;
`endif

  assign opcode_s = ir[15:13];
  assign unused_s = &{1'b0, ir[12], ir[7:0], mem_ready};

  // Next-state, condition-code and strobe decode.
  always_comb begin
    state_d      = state_q;
    cc_d         = cc_q;
    ir_en        = 1'b0;
    pc_inc       = 1'b0;
    pc_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    alu_func     = 3'd0;
    branch_taken = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_en  = done_s;
        pc_inc = done_s;
        if (done_s) state_d = S_EXECUTE;
        else        state_d = S_FETCH;
      end
      S_EXECUTE: begin
        case (opcode_s)
          3'd6: state_d = S_MEMORY;
          3'd7: begin
            branch_taken = cond_eval(ir[11:8], cc_q);
            pc_wr        = branch_taken;
            state_d      = S_FETCH;
          end
          default: begin
            alu_func = opcode_s;
            reg_wr   = 1'b1;
            if (ir[11]) cc_d = alu_flags;
            else        cc_d = cc_q;
            state_d  = S_FETCH;
          end
        endcase
      end
      S_MEMORY: begin
        if (ir[11]) begin
          mem_wr = 1'b1;
        end else begin
          mem_rd = 1'b1;
          reg_wr = done_s;
        end
        if (done_s) state_d = S_FETCH;
        else        state_d = S_MEMORY;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and condition-code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
    end
  end

  assign state_fetch   = (state_q == S_FETCH);
  assign state_execute = (state_q == S_EXECUTE);
  assign state_memory  = (state_q == S_MEMORY);
  assign cc            = cc_q;
  assign alu_c_in      = cc_q[0];

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: instructions are expanded into expected per-cycle traces.
module tb_stump_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ir;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        state_fetch, state_execute, state_memory;
  logic        ir_en, pc_inc, pc_wr, reg_wr, mem_rd, mem_wr;
  logic [2:0]  alu_func;
  logic        alu_c_in;
  logic [3:0]  cc;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        rdy;
    logic [17:0] exp;
  } cyc_t;

  cyc_t       q[$];
  logic [3:0] mcc;

  stump_control dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .state_fetch(state_fetch), .state_execute(state_execute), .state_memory(state_memory),
    .ir_en(ir_en), .pc_inc(pc_inc), .pc_wr(pc_wr), .reg_wr(reg_wr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_func(alu_func), .alu_c_in(alu_c_in),
    .cc(cc), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [17:0] pack(input logic sf, se, sm, ien, pinc, pwr, rwr, mrd, mwr,
                                       input logic [2:0] af, input logic cin,
                                       input logic [3:0] c, input logic bt);
    return {sf, se, sm, ien, pinc, pwr, rwr, mrd, mwr, af, cin, c, bt};
  endfunction

  function automatic logic [17:0] obs();
    return pack(state_fetch, state_execute, state_memory, ir_en, pc_inc, pc_wr, reg_wr,
                mem_rd, mem_wr, alu_func, alu_c_in, cc, branch_taken);
  endfunction

  // Branch condition table written directly from the mnemonic list.
  function automatic bit cond_true(input logic [3:0] code, input logic [3:0] f);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (code)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return !c && !z;
      4'h3: return c || z;
      4'h4: return !c;
      4'h5: return c;
      4'h6: return !z;
      4'h7: return z;
      4'h8: return !v;
      4'h9: return v;
      4'hA: return !n;
      4'hB: return n;
      4'hC: return n == v;
      4'hD: return n != v;
      4'hE: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  function automatic logic rdy_for(input bit fin);
`ifdef STUMP_CTRL_MEM_WAIT_EN
    return fin;
`else
    return 1'($urandom_range(0, 1));
`endif
  endfunction

  // Expand one instruction into its expected cycle trace and advance the model flags.
  task automatic build_instr(input logic [15:0] iv, input logic [3:0] fl, input int fw, input int mw);
    cyc_t c;
    logic [2:0] op;
    logic [3:0] ncc;
    bit fin, st, bt;
    op = iv[15:13];
    for (int k = 0; k <= fw; k++) begin
      fin = (k == fw);
      c.ir = iv; c.flags = 4'($urandom); c.rdy = rdy_for(fin);
      c.exp = pack(1'b1, 1'b0, 1'b0, fin, fin, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, mcc[0], mcc, 1'b0);
      q.push_back(c);
    end
    ncc = mcc;
    c.ir = iv; c.flags = fl; c.rdy = 1'($urandom);
    if (op < 3'd6) begin
      c.exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, op, mcc[0], mcc, 1'b0);
      if (iv[11]) ncc = fl;
    end else if (op == 3'd6) begin
      c.exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, mcc[0], mcc, 1'b0);
    end else begin
      bt = cond_true(iv[11:8], mcc);
      c.exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bt, 1'b0, 1'b0, 1'b0, 3'd0, mcc[0], mcc, bt);
    end
    q.push_back(c);
    mcc = ncc;
    if (op == 3'd6) begin
      st = iv[11];
      for (int k = 0; k <= mw; k++) begin
        fin = (k == mw);
        c.ir = iv; c.flags = 4'($urandom); c.rdy = rdy_for(fin);
        c.exp = pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, fin && !st, !st, st, 3'd0, mcc[0], mcc, 1'b0);
        q.push_back(c);
      end
    end
  endtask

  task automatic test_reset();
    cyc_t c;
    logic [17:0] rst_vec;
    rst_vec = pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    #2;
    checks++;
    if (obs() !== rst_vec) begin
      errors++; $display("FAIL reset_initial: dut=%h expected=%h", obs(), rst_vec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mcc = 4'd0;
    build_instr(16'h0800, 4'hF, 0, 0);
    build_instr(16'h0800, 4'h5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL reset_pre cycle %0d: dut=%h expected=%h", i, obs(), c.exp);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== rst_vec) begin
      errors++; $display("FAIL reset_mid_execute: dut=%h expected=%h", obs(), rst_vec);
    end
    @(posedge clk); #1;
    checks++;
    if (obs() !== rst_vec) begin
      errors++; $display("FAIL reset_held: dut=%h expected=%h", obs(), rst_vec);
    end
    rst_n = 1'b1;
    q.delete();
    mcc = 4'd0;
    build_instr(16'h2800, 4'h3, 0, 0);
    build_instr(16'h0000, 4'h8, 0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL reset_resume: dut=%h expected=%h", obs(), c.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    cyc_t c;
    build_instr(16'h0800, 4'h5, 0, 0);
    build_instr(16'h0000, 4'hA, 0, 0);
    build_instr(16'h2000, 4'h0, 0, 0);
    build_instr(16'hA9FF, 4'h9, 0, 0);
    build_instr(16'h6B00, 4'hE, 0, 0);
    build_instr(16'h8000, 4'h1, 0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL alu ir=%h: dut=%h expected=%h", c.ir, obs(), c.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    cyc_t c;
    build_instr(16'h0800, 4'h4, 0, 0);
    build_instr(16'hE700, 4'h0, 0, 0);
    build_instr(16'hE100, 4'hF, 0, 0);
    build_instr(16'h0800, 4'h0, 0, 0);
    build_instr(16'hE700, 4'hF, 0, 0);
    build_instr(16'hE0AA, 4'h0, 0, 0);
    build_instr(16'hE100, 4'h0, 0, 0);
    build_instr(16'hEE00, 4'h0, 0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL branch ir=%h: dut=%h expected=%h", c.ir, obs(), c.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldst();
    cyc_t c;
    build_instr(16'h0800, 4'h6, 0, 0);
    build_instr(16'hC000, 4'h9, 0, 0);
    build_instr(16'hC800, 4'hF, 0, 0);
    build_instr(16'hCF00, 4'h1, 0, 0);
    build_instr(16'h2000, 4'h0, 0, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL ldst ir=%h: dut=%h expected=%h", c.ir, obs(), c.exp);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef STUMP_CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    cyc_t c;
    build_instr(16'hC000, 4'h7, 0, 3);
    build_instr(16'hC800, 4'h7, 2, 1);
    build_instr(16'h0800, 4'hC, 1, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
      #1;
      checks++;
      if (obs() !== c.exp) begin
        errors++; $display("FAIL mem_wait ir=%h: dut=%h expected=%h", c.ir, obs(), c.exp);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_random();
    cyc_t c;
    int fw, mw;
    for (int n = 0; n < 200; n++) begin
      fw = 0; mw = 0;
`ifdef STUMP_CTRL_MEM_WAIT_EN
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 2));
`endif
      build_instr(16'($urandom), 4'($urandom), fw, mw);
      while (q.size() > 0) begin
        c = q.pop_front();
        ir = c.ir; alu_flags = c.flags; mem_ready = c.rdy;
        #1;
        checks++;
        if (obs() !== c.exp) begin
          errors++; $display("FAIL random ir=%h: dut=%h expected=%h", c.ir, obs(), c.exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ir = 16'd0;
    alu_flags = 4'd0;
    mem_ready = 1'b1;
    mcc = 4'd0;
    test_reset();
    test_alu();
    test_branch();
    test_ldst();
`ifdef STUMP_CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
